// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes,
// funct codes, ALU ctrl values and datapath mux selects.
package multicycle_ctrl_pkg;

  // FSM state encodings; 14 and 15 are unused and recover to FETCH
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ANDIEX  = 4'd10;
  localparam logic [3:0] S_ORIEX   = 4'd11;
  localparam logic [3:0] S_IMMWB   = 4'd12;
  localparam logic [3:0] S_JEX     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's aluop class and a funct code to
// the 3-bit ALU ctrl, flagging funct codes that are not supported.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_bad
);

  always_comb begin
    alu_ctrl  = ALU_ADD;
    funct_bad = 1'b0;
    case (aluop)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_AND:   alu_ctrl = ALU_AND;
          F_OR:    alu_ctrl = ALU_OR;
          F_SLT:   alu_ctrl = ALU_SLT;
          default: funct_bad = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle datapath: registered state, next-state logic
// and per-state combinational decode of mux selects, write enables and ALU ctrl.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int LOGIC_IMM = 1,
  parameter int CTRL_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              zero_ext,
  output logic              i_or_d,
  output logic              ir_write,
  output logic              mem_write,
  output logic              reg_write,
  output logic              pc_en,
  output logic [1:0]        pc_src,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              illegal_op
);

  localparam logic LOGIC_IMM_EN = (LOGIC_IMM != 0);

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic [3:0] decode_target;
  logic       op_legal;
  logic       state_valid;
  aluop_e     aluop;
  logic [5:0] dec_funct;
  logic [2:0] dec_ctrl;
  logic       funct_bad;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .aluop     (aluop),
    .funct     (dec_funct),
    .alu_ctrl  (dec_ctrl),
    .funct_bad (funct_bad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Opcode dispatch out of DECODE; disabled logic immediates count as illegal
  always_comb begin
    op_legal      = 1'b1;
    decode_target = S_FETCH;
    case (op)
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_RTYPE:     decode_target = S_RTYPEEX;
      OP_BEQ:       decode_target = S_BEQEX;
      OP_ADDI:      decode_target = S_ADDIEX;
      OP_ANDI: begin
        op_legal      = LOGIC_IMM_EN;
        decode_target = LOGIC_IMM_EN ? S_ANDIEX : S_FETCH;
      end
      OP_ORI: begin
        op_legal      = LOGIC_IMM_EN;
        decode_target = LOGIC_IMM_EN ? S_ORIEX : S_FETCH;
      end
      OP_J:         decode_target = S_JEX;
      default:      op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  state_next = decode_target;
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_next = funct_bad ? S_FETCH : S_RTYPEWB;
      S_ADDIEX, S_ANDIEX, S_ORIEX: state_next = S_IMMWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // Logic immediates reuse the funct path with a fixed funct code
  always_comb begin
    aluop     = ALUOP_ADD;
    dec_funct = funct;
    case (state_reg)
      S_RTYPEEX: aluop = ALUOP_FUNCT;
      S_BEQEX:   aluop = ALUOP_SUB;
      S_ANDIEX: begin
        aluop     = ALUOP_FUNCT;
        dec_funct = F_AND;
      end
      S_ORIEX: begin
        aluop     = ALUOP_FUNCT;
        dec_funct = F_OR;
      end
      default: aluop = ALUOP_ADD;
    endcase
  end

  always_comb begin
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REG;
    zero_ext    = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PCSRC_ALU;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;
    state_valid = 1'b1;
    case (state_reg)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a  = 1'b1;
        illegal_op = funct_bad;
      end
      S_RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ANDIEX, S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        zero_ext  = 1'b1;
      end
      S_IMMWB: reg_write = 1'b1;
      S_JEX: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      default: state_valid = 1'b0;
    endcase
    // Reset masks the state still held from an abandoned instruction
    if (reset) begin
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      zero_ext   = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      pc_en      = 1'b0;
      pc_src     = PCSRC_ALU;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign alu_ctrl = reset       ? CTRL_W'(ALU_ADD) :
                    state_valid ? CTRL_W'(dec_ctrl) : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle-sequence model driving one
// compare process over two instances (logic immediates enabled and disabled).
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic [2:0] a_alu_ctrl, b_alu_ctrl;
  logic       a_src_a, b_src_a;
  logic [1:0] a_src_b, b_src_b;
  logic       a_zext, b_zext, a_iord, b_iord, a_irw, b_irw, a_memw, b_memw;
  logic       a_regw, b_regw, a_pcen, b_pcen;
  logic [1:0] a_pcsrc, b_pcsrc;
  logic       a_regdst, b_regdst, a_m2r, b_m2r, a_ill, b_ill;

  ctl_t act1, act0, exp1, exp0;
  logic exp_valid = 1'b0;
  logic exp0_valid = 1'b0;
  logic lockstep0 = 1'b0;
  string tag = "";
  int checks = 0;
  int errors = 0;
  int n_cyc = 0;
  int regw_total = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.LOGIC_IMM(1), .CTRL_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_ctrl(a_alu_ctrl), .alu_src_a(a_src_a), .alu_src_b(a_src_b), .zero_ext(a_zext),
    .i_or_d(a_iord), .ir_write(a_irw), .mem_write(a_memw), .reg_write(a_regw),
    .pc_en(a_pcen), .pc_src(a_pcsrc), .reg_dst(a_regdst), .mem_to_reg(a_m2r),
    .illegal_op(a_ill)
  );

  multicycle_ctrl #(.LOGIC_IMM(0), .CTRL_W(3)) dut_nolog (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_ctrl(b_alu_ctrl), .alu_src_a(b_src_a), .alu_src_b(b_src_b), .zero_ext(b_zext),
    .i_or_d(b_iord), .ir_write(b_irw), .mem_write(b_memw), .reg_write(b_regw),
    .pc_en(b_pcen), .pc_src(b_pcsrc), .reg_dst(b_regdst), .mem_to_reg(b_m2r),
    .illegal_op(b_ill)
  );

  assign act1 = {a_alu_ctrl, a_src_a, a_src_b, a_zext, a_iord, a_irw, a_memw, a_regw,
                 a_pcen, a_pcsrc, a_regdst, a_m2r, a_ill};
  assign act0 = {b_alu_ctrl, b_src_a, b_src_b, b_zext, b_iord, b_irw, b_memw, b_regw,
                 b_pcen, b_pcsrc, b_regdst, b_m2r, b_ill};

  // Sample away from the active edge, one line per mismatching transaction
  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act1 !== exp1) begin
        errors++;
        $display("FAIL %s [LOGIC_IMM=1]: got %05h required %05h", tag, act1, exp1);
      end
    end
    if (exp0_valid) begin
      checks++;
      if (act0 !== exp0) begin
        errors++;
        $display("FAIL %s [LOGIC_IMM=0]: got %05h required %05h", tag, act0, exp0);
      end
    end
  end

  function automatic ctl_t base();
    ctl_t e;
    e = '0;
    e.alu_ctrl = 3'd2;
    return e;
  endfunction

  // {supported, ctrl} for an R-type funct
  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 3'd2};
      6'b100010: return {1'b1, 3'd6};
      6'b100100: return {1'b1, 3'd0};
      6'b100101: return {1'b1, 3'd1};
      6'b101010: return {1'b1, 3'd7};
      default:   return {1'b0, 3'd2};
    endcase
  endfunction

  task automatic cyc(input ctl_t e1, input ctl_t e0, input string t);
    exp1 = e1;
    exp0 = e0;
    exp_valid = 1'b1;
    exp0_valid = lockstep0;
    tag = t;
    regw_total += int'(e1.reg_write);
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    mem_ready = 1'b0;
    lockstep0 = 1'b1;
    for (int i = 0; i < n; i++) cyc(base(), base(), "reset");
    reset = 1'b0;
  endtask

  task automatic fetch(input int waits, input string name);
    ctl_t e;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      e = base();
      e.alu_src_b = 2'b01;
      cyc(e, e, {name, " fetch-wait"});
    end
    mem_ready = 1'b1;
    e = base();
    e.alu_src_b = 2'b01;
    e.ir_write = 1'b1;
    e.pc_en = 1'b1;
    cyc(e, e, {name, " fetch"});
    mem_ready = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op_v, input logic [5:0] funct_v, input logic zero_v,
                           input int fwait, input int mwait, input int want_cyc,
                           input int want_regw, input string name);
    ctl_t e, e0;
    logic [3:0] rf;
    logic is_logic, legal;
    int c0, r0;
    c0 = n_cyc;
    r0 = regw_total;
    op = op_v;
    funct = funct_v;
    zero = zero_v;
    fetch(fwait, name);
    is_logic = (op_v == OP_ANDI) || (op_v == OP_ORI);
    legal = is_logic || op_v inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J};
    e = base();
    e.alu_src_b = 2'b11;
    if (!legal) begin
      e.illegal_op = 1'b1;
      cyc(e, e, {name, " decode"});
    end else begin
      e0 = e;
      e0.illegal_op = is_logic;
      cyc(e, e0, {name, " decode"});
      if (is_logic) lockstep0 = 1'b0;
      e = base();
      if (op_v == OP_LW || op_v == OP_SW) begin
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        cyc(e, e, {name, " address"});
        for (int i = 0; i <= mwait; i++) begin
          mem_ready = (i == mwait);
          e = base();
          e.i_or_d = 1'b1;
          e.mem_write = (op_v == OP_SW);
          cyc(e, e, {name, " mem access"});
        end
        mem_ready = 1'b0;
        if (op_v == OP_LW) begin
          e = base();
          e.mem_to_reg = 1'b1;
          e.reg_write = 1'b1;
          cyc(e, e, {name, " load writeback"});
        end
      end else if (op_v == OP_R) begin
        rf = r_alu(funct_v);
        e.alu_src_a = 1'b1;
        if (rf[3]) e.alu_ctrl = rf[2:0];
        else e.illegal_op = 1'b1;
        cyc(e, e, {name, " execute"});
        if (rf[3]) begin
          e = base();
          e.reg_dst = 1'b1;
          e.reg_write = 1'b1;
          cyc(e, e, {name, " writeback"});
        end
      end else if (op_v == OP_BEQ) begin
        e.alu_src_a = 1'b1;
        e.alu_ctrl = 3'd6;
        e.pc_src = 2'b01;
        e.pc_en = zero_v;
        cyc(e, e, {name, " branch"});
      end else if (op_v == OP_J) begin
        e.pc_src = 2'b10;
        e.pc_en = 1'b1;
        cyc(e, e, {name, " jump"});
      end else begin
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        e.alu_ctrl = (op_v == OP_ADDI) ? 3'd2 : (op_v == OP_ANDI) ? 3'd0 : 3'd1;
        e.zero_ext = is_logic;
        cyc(e, e, {name, " execute"});
        e = base();
        e.reg_write = 1'b1;
        cyc(e, e, {name, " writeback"});
      end
    end
    check_int({name, " cycles"}, n_cyc - c0, want_cyc);
    check_int({name, " reg_write pulses"}, regw_total - r0, want_regw);
  endtask

  initial begin
    ctl_t e;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(OP_LW,   6'd0,      1'b0, 0, 0, 5, 1, "lw");
    run_instr(OP_LW,   6'd0,      1'b0, 2, 1, 8, 1, "lw waits");
    run_instr(OP_SW,   6'd0,      1'b0, 0, 0, 4, 0, "sw");
    run_instr(OP_SW,   6'd0,      1'b0, 1, 2, 7, 0, "sw waits");
    run_instr(OP_R,    6'b100000, 1'b0, 0, 0, 4, 1, "add");
    run_instr(OP_R,    6'b100010, 1'b0, 0, 0, 4, 1, "sub");
    run_instr(OP_R,    6'b100100, 1'b0, 0, 0, 4, 1, "and");
    run_instr(OP_R,    6'b100101, 1'b0, 0, 0, 4, 1, "or");
    run_instr(OP_R,    6'b101010, 1'b0, 0, 0, 4, 1, "slt");
    run_instr(OP_R,    6'b111111, 1'b0, 0, 0, 3, 0, "bad funct");
    run_instr(OP_BEQ,  6'd0,      1'b1, 0, 0, 3, 0, "beq taken");
    run_instr(OP_BEQ,  6'd0,      1'b0, 0, 0, 3, 0, "beq not taken");
    run_instr(OP_ADDI, 6'd0,      1'b0, 0, 0, 4, 1, "addi");
    run_instr(OP_J,    6'd0,      1'b0, 0, 0, 3, 0, "j");
    run_instr(6'b111111, 6'd0,    1'b0, 0, 0, 2, 0, "bad op");
    run_instr(OP_ANDI, 6'd0,      1'b0, 0, 0, 4, 1, "andi");
    do_reset(1);
    run_instr(OP_ORI,  6'd0,      1'b0, 0, 0, 4, 1, "ori");
    do_reset(1);

    // Abandon a store while it waits on memory
    op = OP_SW;
    fetch(0, "sw abort");
    e = base();
    e.alu_src_b = 2'b11;
    cyc(e, e, "sw abort decode");
    e = base();
    e.alu_src_a = 1'b1;
    e.alu_src_b = 2'b10;
    cyc(e, e, "sw abort address");
    e = base();
    e.i_or_d = 1'b1;
    e.mem_write = 1'b1;
    cyc(e, e, "sw abort mem wait");
    do_reset(3);
    run_instr(OP_LW, 6'd0, 1'b0, 0, 0, 5, 1, "lw after abort");

    exp_valid = 1'b0;
    exp0_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
